// File: rtl/axis_spi_tx_if.sv
// AXI-Stream word channel feeding the SPI transmitter.
// The source uses the master modport and the transmitter uses the slave modport.
interface axis_spi_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_tx.sv
// AXI-Stream sink to SPI mode-0 master transmitter; frames are delimited by tlast.
// Define AXIS_SPI_TX_LSB_FIRST_EN to shift words LSB first (default build: MSB first).
module axis_spi_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    axis_spi_tx_if.slave s_axis,
    output logic         scko_o,
    output logic         mo_o,
    output logic         csn_o,
    output logic         busy_o
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        NEXT  = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              last_q, last_d;
    logic              scko_q, scko_d;
    logic              mo_q, mo_d;
    logic              csn_q, csn_d;
    logic              tready_q, tready_d;
    logic              hs;
    logic              div_done;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
`ifdef AXIS_SPI_TX_LSB_FIRST_EN
        return w[0];
`else
        return w[DATA_W-1];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
`ifdef AXIS_SPI_TX_LSB_FIRST_EN
        return {1'b0, w[DATA_W-1:1]};
`else
        return {w[DATA_W-2:0], 1'b0};
`endif
    endfunction

    assign hs       = s_axis.tvalid & tready_q;
    assign div_done = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        last_d   = last_q;
        scko_d   = scko_q;
        mo_d     = mo_q;
        csn_d    = csn_q;
        tready_d = tready_q;

        case (state_q)
            IDLE: begin
                csn_d    = 1'b1;
                scko_d   = 1'b0;
                mo_d     = 1'b0;
                tready_d = 1'b1;
                if (hs) begin
                    sreg_d   = s_axis.tdata;
                    last_d   = s_axis.tlast;
                    mo_d     = first_bit(s_axis.tdata);
                    csn_d    = 1'b0;
                    tready_d = 1'b0;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = LEAD;
                end
            end
            LEAD: begin
                if (div_done) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_d  = '0;
                    scko_d = ~scko_q;
                    // Falling edge: advance to the next bit, or leave after the final bit.
                    if (scko_q) begin
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
                            if (last_q) begin
                                state_d = TRAIL;
                            end else begin
                                state_d  = NEXT;
                                tready_d = 1'b1;
                            end
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            sreg_d = shift_word(sreg_q);
                            mo_d   = first_bit(shift_word(sreg_q));
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            NEXT: begin
                scko_d   = 1'b0;
                tready_d = 1'b1;
                if (hs) begin
                    sreg_d   = s_axis.tdata;
                    last_d   = s_axis.tlast;
                    mo_d     = first_bit(s_axis.tdata);
                    tready_d = 1'b0;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = SHIFT;
                end
            end
            TRAIL: begin
                if (div_done) begin
                    div_d   = '0;
                    csn_d   = 1'b1;
                    mo_d    = 1'b0;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_done) begin
                    div_d    = '0;
                    tready_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                div_d    = '0;
                bit_d    = '0;
                scko_d   = 1'b0;
                mo_d     = 1'b0;
                csn_d    = 1'b1;
                tready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            sreg_q   <= '0;
            last_q   <= 1'b0;
            scko_q   <= 1'b0;
            mo_q     <= 1'b0;
            csn_q    <= 1'b1;
            tready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sreg_q   <= sreg_d;
            last_q   <= last_d;
            scko_q   <= scko_d;
            mo_q     <= mo_d;
            csn_q    <= csn_d;
            tready_q <= tready_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign scko_o        = scko_q;
    assign mo_o          = mo_q;
    assign csn_o         = csn_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_axis_spi_tx.sv
// Scoreboard bench for axis_spi_tx: stimulus queues expected words/frames, a monitor
// decodes the SPI bus and compares. Instance A uses CLK_DIV=2, instance B uses CLK_DIV=1.
module tb_axis_spi_tx;
`ifdef AXIS_SPI_TX_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    typedef struct {
        int len;
        int rises;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       sel;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       s_tvalid;
    logic       scko_a, mo_a, csn_a, busy_a;
    logic       scko_b, mo_b, csn_b, busy_b;
    logic       m_scko, m_mo, m_csn, m_busy, m_tready;
    int         cd;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_words[$];
    frame_t     exp_frames[$];
    int         rises;

    axis_spi_tx_if #(.DATA_W(8)) if_a ();
    axis_spi_tx_if #(.DATA_W(8)) if_b ();

    assign if_a.tdata  = s_tdata;
    assign if_a.tlast  = s_tlast;
    assign if_a.tvalid = s_tvalid & ~sel;
    assign if_b.tdata  = s_tdata;
    assign if_b.tlast  = s_tlast;
    assign if_b.tvalid = s_tvalid & sel;

    axis_spi_tx #(.DATA_W(8), .CLK_DIV(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .s_axis(if_a),
        .scko_o(scko_a), .mo_o(mo_a), .csn_o(csn_a), .busy_o(busy_a)
    );
    axis_spi_tx #(.DATA_W(8), .CLK_DIV(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .s_axis(if_b),
        .scko_o(scko_b), .mo_o(mo_b), .csn_o(csn_b), .busy_o(busy_b)
    );

    assign m_scko   = sel ? scko_b : scko_a;
    assign m_mo     = sel ? mo_b : mo_a;
    assign m_csn    = sel ? csn_b : csn_a;
    assign m_busy   = sel ? busy_b : busy_a;
    assign m_tready = sel ? if_b.tready : if_a.tready;
    assign cd       = sel ? 1 : 2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: decode bits at scko rises, measure csn low time and scko high pulses.
    initial begin
        logic       in_frame = 1'b0;
        logic       prev_scko = 1'b0;
        logic [7:0] acc = '0;
        int         nbits = 0;
        int         low_cnt = 0;
        int         hi_cnt = 0;
        frame_t     f;
        logic [7:0] w;
        rises = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 1'b0;
                prev_scko = 1'b0;
                acc       = '0;
                nbits     = 0;
                low_cnt   = 0;
                hi_cnt    = 0;
                rises     = 0;
            end else begin
                if (!m_csn) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        low_cnt  = 0;
                        rises    = 0;
                    end
                    low_cnt++;
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    check("frame_expected", exp_frames.size() > 0, 1);
                    if (exp_frames.size() > 0) begin
                        f = exp_frames.pop_front();
                        if (f.len >= 0) check("csn_low_cycles", low_cnt, f.len);
                        check("scko_rises", rises, f.rises);
                    end
                    check("partial_bits", nbits, 0);
                    check("mo_idle_low", m_mo, 0);
                    nbits = 0;
                end
                if (m_scko && !prev_scko) begin
                    check("rise_inside_cs", m_csn, 0);
                    rises++;
                    acc = LSB ? {m_mo, acc[7:1]} : {acc[6:0], m_mo};
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        check("word_expected", exp_words.size() > 0, 1);
                        if (exp_words.size() > 0) begin
                            w = exp_words.pop_front();
                            check("word_bits", acc, w);
                        end
                    end
                end
                if (!m_scko && prev_scko) check("scko_high_cycles", hi_cnt, cd);
                hi_cnt    = m_scko ? hi_cnt + 1 : 0;
                prev_scko = m_scko;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input bit hold);
        int n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!m_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("handshake_in_time", m_tready, 1);
        @(negedge clk);
        if (!hold) s_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit scramble);
        int n = 0;
        while (!(!m_busy && m_tready) && n < budget) begin
            @(negedge clk);
            if (scramble) begin
                s_tdata = 8'($urandom);
                s_tlast = 1'($urandom);
            end
            n++;
        end
        check("return_to_idle", !m_busy && m_tready, 1);
        check("idle_csn_high", m_csn, 1);
    endtask

    initial begin
        int n;
        int bad;
        sel      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tready", m_tready, 0);
        check("rst_csn", m_csn, 1);
        check("rst_scko", m_scko, 0);
        check("rst_mo", m_mo, 0);
        check("rst_busy", m_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_reset", m_tready, 1);

        // Single word frame.
        exp_frames.push_back('{36, 8});
        exp_words.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        wait_idle(200, 1'b0);

        // Three-word frame, tvalid held high: one NEXT cycle between words.
        exp_frames.push_back('{102, 24});
        exp_words.push_back(8'h01);
        exp_words.push_back(8'h80);
        exp_words.push_back(8'hFF);
        send(8'h01, 1'b0, 1'b1);
        send(8'h80, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b0);
        wait_idle(400, 1'b0);

        // Source stalls between words of one frame.
        exp_frames.push_back('{-1, 16});
        exp_words.push_back(8'h3C);
        exp_words.push_back(8'hC3);
        send(8'h3C, 1'b0, 1'b0);
        n = 0;
        while (!m_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("next_reached", m_tready, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (m_scko !== 1'b0 || m_tready !== 1'b1 || m_csn !== 1'b0 || m_busy !== 1'b1) bad++;
        end
        check("next_wait_bad_samples", bad, 0);
        send(8'hC3, 1'b1, 1'b0);
        wait_idle(200, 1'b0);

        // Reset after the third rise of 0xFF aborts the word.
        send(8'hFF, 1'b1, 1'b0);
        n = 0;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("third_rise_reached", rises, 3);
        rst = 1'b1;
        #1;
        check("abort_csn", m_csn, 1);
        check("abort_scko", m_scko, 0);
        check("abort_mo", m_mo, 0);
        check("abort_tready", m_tready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_scko !== 1'b0 || m_csn !== 1'b1) bad++;
        end
        check("post_reset_quiet", bad, 0);
        exp_frames.push_back('{36, 8});
        exp_words.push_back(8'h81);
        send(8'h81, 1'b1, 1'b0);
        wait_idle(200, 1'b0);

        // CLK_DIV=1 instance; payload scrambled while tready is low.
        sel = 1'b1;
        @(negedge clk);
        exp_frames.push_back('{18, 8});
        exp_words.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0);
        wait_idle(200, 1'b1);

        repeat (5) @(negedge clk);
        check("words_left", exp_words.size(), 0);
        check("frames_left", exp_frames.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
